// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the LIFO stack: default geometry, the per-edge
// action encoding and the action decode helper.
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int unsigned STACK_WIDTH = 8;
    localparam int unsigned STACK_DEPTH = 16;

    // One action per falling edge. PUSH_FULL / POP_EMPTY are the illegal
    // requests: they leave sp and the array alone and only raise a flag.
    typedef enum logic [2:0] {
        HOLD,
        PUSH,
        POP,
        REPLACE,
        PUSH_FULL,
        POP_EMPTY
    } stack_op_e;

    // push+pop on an empty stack has no top to replace, so it becomes a push.
    function automatic stack_op_e stack_decode(
        input logic push,
        input logic pop,
        input logic full,
        input logic empty
    );
        stack_op_e op;
        unique case ({push, pop})
            2'b10:   op = full  ? PUSH_FULL : PUSH;
            2'b01:   op = empty ? POP_EMPTY : POP;
            2'b11:   op = empty ? PUSH      : REPLACE;
            default: op = HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_storage.sv
// -----------------------------------------------------------------------------
// stack_storage
// Generic storage array: one synchronous write port clocked on the falling
// edge of nclk, one asynchronous (combinational) read port. Contents are not
// reset.
//
// Ports:
//   nclk     in   clock, writes on the falling edge
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr, zero latency
// -----------------------------------------------------------------------------
module stack_storage #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             nclk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(negedge nclk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_memory.sv
// -----------------------------------------------------------------------------
// stack_memory
// Parametrised LIFO stack for CALL/RET and PUSH/POP. State advances on the
// falling edge of nclk; status and top-of-stack are combinational.
//
// Optional feature macro: STACK_ERR_EN
//   defined   -> overflow/underflow sticky flags and err_clr exist
//   undefined -> those ports and registers are absent; illegal requests are
//                silently ignored
//
// Ports:
//   nclk       in   clock, state updates on the falling edge
//   nrst       in   asynchronous active-low reset
//   push       in   push request
//   pop        in   pop request (push+pop = replace top)
//   data_in    in   word to push / replacement value
//   top        out  top-of-stack word, 0 when empty
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   err_clr    in   clear both error flags            (STACK_ERR_EN only)
//   overflow   out  sticky push-when-full flag        (STACK_ERR_EN only)
//   underflow  out  sticky pop-when-empty flag        (STACK_ERR_EN only)
// -----------------------------------------------------------------------------
module stack_memory
    import stack_pkg::*;
#(
    parameter  int unsigned WIDTH = STACK_WIDTH,
    parameter  int unsigned DEPTH = STACK_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             nclk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full
`ifdef STACK_ERR_EN
    ,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
`endif
);

    logic [AW:0]      sp;
    stack_op_e        op;
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    assign count   = sp;
    assign empty   = (sp == '0);
    assign full    = (sp == (AW+1)'(DEPTH));
    // Wraps to DEPTH-1 when empty; top is forced to 0 in that case.
    assign rd_addr = AW'(sp - 1'b1);
    assign top     = empty ? '0 : rd_data;

    always_comb begin
        op = stack_decode(push, pop, full, empty);
    end

    // A request arriving while reset is held must not touch the array either.
    always_comb begin
        we      = 1'b0;
        wr_addr = sp[AW-1:0];
        unique case (op)
            PUSH:    we = nrst;
            REPLACE: begin
                we      = nrst;
                wr_addr = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(negedge nclk or negedge nrst) begin
        if (!nrst) begin
            sp <= '0;
        end else begin
            unique case (op)
                PUSH:    sp <= sp + 1'b1;
                POP:     sp <= sp - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef STACK_ERR_EN
    // err_clr wins over a flag being set on the same edge.
    always_ff @(negedge nclk or negedge nrst) begin
        if (!nrst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (op == PUSH_FULL) overflow  <= 1'b1;
            if (op == POP_EMPTY) underflow <= 1'b1;
        end
    end
`endif

    stack_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .nclk    (nclk),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: doc/stack_memory.md
# stack_memory

Parametrised hardware LIFO stack for the simple microprocessor, the next generation of our register-file/RAM storage blocks. It holds return addresses and operands for CALL/RET and PUSH/POP instructions, with width and depth generalised, explicit full/empty status, a push+pop replace-top mode and optional error flags. It sits beside the register file and RAM on the same `nclk` domain and is driven by the control unit.

## Interface
- `WIDTH`, 8: data word width in bits (≥1).
- `DEPTH`, 16: number of entries, power of two, ≥2; local `AW = $clog2(DEPTH)`.
- `nclk`  in  1  clock; all state updates on the falling edge, as for the register file and RAM.
- `nrst`  in  1  reset, asynchronous, active-low.
- `push`  in  1  push request, sampled at the `nclk` falling edge.
- `pop`  in  1  pop request, sampled at the `nclk` falling edge.
- `data_in`  in  WIDTH  word to push, or the replacement value for replace-top.
- `top`  out  WIDTH  current top-of-stack word; 0 when empty.
- `count`  out  AW+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky push-when-full flag (only with `STACK_ERR_EN`).
- `underflow`  out  1  sticky pop-when-empty flag (only with `STACK_ERR_EN`).
- `err_clr`  in  1  synchronous clear for both error flags (only with `STACK_ERR_EN`).

## Operation
- State: stack pointer `sp` (AW+1 bits, 0..DEPTH) plus the storage array. `count = sp`. Top entry is `mem[sp-1]`.
- Reset (`nrst` low, asynchronous): `sp=0`, `overflow=0`, `underflow=0`. Outputs become `count=0`, `empty=1`, `full=0`, `top=0`. Array contents are not cleared and are never observable while empty.
- Reset asserted mid-operation discards any request in flight. The first edge after `nrst` rises operates normally.
- Per falling edge, exactly one action, chosen by `{push,pop}` and occupancy:
  - 00: hold.
  - 10, not full: `mem[sp] <= data_in`, `sp <= sp+1`.
  - 10, full: no write, `sp` held; set `overflow`.
  - 01, not empty: `sp <= sp-1`. Contents are untouched.
  - 01, empty: `sp` held; set `underflow`.
  - 11, not empty (includes full): replace top, `mem[sp-1] <= data_in`, `sp` held; no flag set.
  - 11, empty: treated as a push (`mem[0] <= data_in`, `sp <= 1`); no flag set.
- `sp` never wraps: it never exceeds DEPTH and never drops below 0.
- `err_clr` takes priority over a flag set on the same edge. Both flags end up 0.

## Timing
- `top`, `count`, `empty` and `full` are combinational from `sp` and the array, with zero read latency.
- After a push edge, `top == data_in` becomes visible in the same half-period that follows. The control unit samples on the rising edge.
- Requests are single-cycle: there is no handshake, and a request is consumed on every edge at which it is high.
- `overflow`/`underflow` rise right after the offending edge and stay high until `err_clr` or reset.

## Configuration
- `STACK_ERR_EN` defined: the `overflow`, `underflow` and `err_clr` ports and their flag registers exist, behaving as described above.
- `STACK_ERR_EN` undefined: those ports and registers are absent. Illegal push/pop are still silently ignored, with identical `sp`/array behaviour.

## Structure
- Package `stack_pkg`: the default `WIDTH`/`DEPTH` constants, and a `stack_op_e` enum (HOLD, PUSH, POP, REPLACE, PUSH_FULL, POP_EMPTY) used by the action decode.
- Sub-module `stack_storage`: parametrised array with one write port on the `nclk` falling edge and one combinational read port. It is reusable as the generalised RAM core.
- `stack_memory` contains the `sp` register, the action decode and the flags.

## Test plan
- Reset, then 4 pushes of 0x11, 0x22, 0x33, 0x44 -> `count=4`, `top=0x44`, `empty=0`.
- With `DEPTH=16`, push 16 words, then push 0xAA -> `full=1`, `count=16`, `top` = 16th word, `overflow=1`; then `err_clr` -> `overflow=0`.
- From empty, pop -> `count=0`, `top=0`, `underflow=1`; then push+pop with 0x5A -> `count=1`, `top=0x5A`.
- Push 0x01, 0x02, then push+pop with 0x7F -> `count=2`, `top=0x7F`; pop -> `top=0x01`.
- Push 3 words, assert `nrst` low between edges -> immediately `count=0`, `empty=1`, `top=0`, flags 0; next push 0x09 -> `top=0x09`, `count=1`.
- Build without `STACK_ERR_EN`, rerun the overflow/underflow scenarios -> same `count`/`top` results and no error ports.
